// File: rtl/move_judge.sv
// move_judge: cursor ownership, candidate-board construction and sequential
// win/draw judgement for the tic-tac-toe update stage.
//
// Board encoding: cell i at bits [2i+1:2i]; 00 empty, 01 A, 10 B.
// Game states: 00 PLAY, 01 A wins, 10 B wins, 11 DRAW.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   left_btn, right_btn cursor buttons (synchronous levels, rising edge acts)
//   curr_move           committed board from the update stage
//   curr_turn           player to move (01 A, 10 B)
//   curr_state          committed game state
//   cursor              selected cell, 0..8
//   next_move           judged candidate board
//   next_state          judged state of the candidate board
//   valid_move          candidate is legal and judgement complete
//   busy                scan in progress
//   win_line, win_hit   first winning line index / hit flag (WIN_LINE_EN only)
//
// Optional feature macro: WIN_LINE_EN adds the win_line/win_hit outputs.
module move_judge #(
  parameter int unsigned CELLS        = 9,
  parameter int unsigned RESET_CURSOR = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        left_btn,
  input  logic        right_btn,
  input  logic [17:0] curr_move,
  input  logic [1:0]  curr_turn,
  input  logic [1:0]  curr_state,
  output logic [3:0]  cursor,
  output logic [17:0] next_move,
  output logic [1:0]  next_state,
  output logic        valid_move,
  output logic        busy
`ifdef WIN_LINE_EN
  ,
  output logic [2:0]  win_line,
  output logic        win_hit
`endif
);

  localparam logic [3:0] LastCell    = 4'(CELLS - 1);
  localparam logic [3:0] ResetCursor = 4'(RESET_CURSOR);
  localparam logic [1:0] GsPlay      = 2'b00;
  localparam logic [1:0] GsDraw      = 2'b11;

  typedef enum logic [1:0] {StIdle, StScan, StFinal} state_e;

  // Cell indices of each win line, packed {c2, c1, c0}, in scan order.
  function automatic logic [11:0] line_cells(input logic [2:0] idx);
    logic [11:0] r;
    unique case (idx)
      3'd0:    r = {4'd2, 4'd1, 4'd0};
      3'd1:    r = {4'd5, 4'd4, 4'd3};
      3'd2:    r = {4'd8, 4'd7, 4'd6};
      3'd3:    r = {4'd6, 4'd3, 4'd0};
      3'd4:    r = {4'd7, 4'd4, 4'd1};
      3'd5:    r = {4'd8, 4'd5, 4'd2};
      3'd6:    r = {4'd8, 4'd4, 4'd0};
      default: r = {4'd6, 4'd4, 4'd2};
    endcase
    return r;
  endfunction

  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] i);
    logic [1:0] c;
    c = 2'b00;
    for (int k = 0; k < int'(CELLS); k++) begin
      if (i == 4'(k)) c = b[2*k +: 2];
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cursor_q, cursor_d;
  logic        left_q, right_q;
  logic [3:0]  cursor_prev_q;
  logic [17:0] move_prev_q;
  logic [1:0]  turn_prev_q;
  logic        pending_q, pending_d;
  logic [2:0]  line_q, line_d;
  logic [17:0] cand_q, cand_d;
  logic        legal_q, legal_d;
  logic [1:0]  winner_q, winner_d;
  logic        busy_q, busy_d;
  logic [17:0] next_move_q, next_move_d;
  logic [1:0]  next_state_q, next_state_d;
  logic        valid_q, valid_d;
`ifdef WIN_LINE_EN
  logic [2:0]  win_idx_q, win_idx_d;
  logic [2:0]  win_line_q, win_line_d;
  logic        win_hit_q, win_hit_d;
`endif

  logic        r_edge, l_edge, diff, latch, turn_ok, legal, full;
  logic [1:0]  cur_cell, c0, c1, c2;
  logic [17:0] cand;
  logic [11:0] lc;

  assign r_edge  = right_btn & ~right_q;
  assign l_edge  = left_btn & ~left_q;
  assign diff    = (cursor_q != cursor_prev_q) || (curr_move != move_prev_q) ||
                   (curr_turn != turn_prev_q);
  // A pending change (re)starts the scan from any state; this is also the abort path.
  assign latch   = pending_q;
  assign turn_ok = (curr_turn == 2'b01) || (curr_turn == 2'b10);

  // Cursor movement; simultaneous edges cancel.
  always_comb begin
    cursor_d = cursor_q;
    if (r_edge && !l_edge) begin
      cursor_d = (cursor_q == LastCell) ? 4'd0 : cursor_q + 4'd1;
    end else if (l_edge && !r_edge) begin
      cursor_d = (cursor_q == 4'd0) ? LastCell : cursor_q - 4'd1;
    end
  end

  // Candidate board from the live inputs.
  always_comb begin
    cur_cell = cell_of(curr_move, cursor_q);
    legal    = (cur_cell == 2'b00) && turn_ok;
    cand     = curr_move;
    if (legal) begin
      for (int k = 0; k < int'(CELLS); k++) begin
        if (cursor_q == 4'(k)) cand[2*k +: 2] = curr_turn;
      end
    end
  end

  // Line currently under test and board-full flag of the latched candidate.
  always_comb begin
    lc = line_cells(line_q);
    c0 = cell_of(cand_q, lc[3:0]);
    c1 = cell_of(cand_q, lc[7:4]);
    c2 = cell_of(cand_q, lc[11:8]);
    full = 1'b1;
    for (int k = 0; k < int'(CELLS); k++) begin
      if (cand_q[2*k +: 2] == 2'b00) full = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (latch) state_d = StScan;
      StScan:  if (latch) state_d = StScan;
               else if (line_q == 3'd7) state_d = StFinal;
      StFinal: state_d = latch ? StScan : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    // The change captured by a latch is the one it absorbs, so latch clears pending.
    pending_d    = latch ? 1'b0 : (pending_q | diff);
    line_d       = line_q;
    cand_d       = cand_q;
    legal_d      = legal_q;
    winner_d     = winner_q;
    busy_d       = busy_q;
    next_move_d  = next_move_q;
    next_state_d = next_state_q;
    valid_d      = valid_q;
`ifdef WIN_LINE_EN
    win_idx_d    = win_idx_q;
    win_line_d   = win_line_q;
    win_hit_d    = win_hit_q;
`endif
    if (latch) begin
      cand_d   = cand;
      legal_d  = legal;
      line_d   = 3'd0;
      winner_d = 2'b00;
      busy_d   = 1'b1;
      valid_d  = 1'b0;
`ifdef WIN_LINE_EN
      win_idx_d = 3'd0;
`endif
    end else begin
      unique case (state_q)
        StScan: begin
          // First winning line sticks; later lines are ignored.
          if ((winner_q == 2'b00) && (c0 == c1) && (c1 == c2) &&
              ((c0 == 2'b01) || (c0 == 2'b10))) begin
            winner_d = c0;
`ifdef WIN_LINE_EN
            win_idx_d = line_q;
`endif
          end
          line_d = line_q + 3'd1;
        end
        StFinal: begin
          next_move_d = cand_q;
          if (winner_q != 2'b00) next_state_d = winner_q;
          else if (full)         next_state_d = GsDraw;
          else                   next_state_d = GsPlay;
          valid_d = legal_q && (curr_state == GsPlay);
          busy_d  = 1'b0;
`ifdef WIN_LINE_EN
          win_hit_d  = (winner_q != 2'b00);
          win_line_d = (winner_q != 2'b00) ? win_idx_q : 3'd0;
`endif
        end
        default: ;
      endcase
      // Inputs moved away from what was judged: withhold OK until rejudged.
      if (pending_d) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cursor_q      <= ResetCursor;
      left_q        <= 1'b0;
      right_q       <= 1'b0;
      cursor_prev_q <= ResetCursor;
      move_prev_q   <= '0;
      turn_prev_q   <= 2'b00;
      pending_q     <= 1'b1;
      line_q        <= 3'd0;
      cand_q        <= '0;
      legal_q       <= 1'b0;
      winner_q      <= 2'b00;
      busy_q        <= 1'b0;
      next_move_q   <= '0;
      next_state_q  <= GsPlay;
      valid_q       <= 1'b0;
`ifdef WIN_LINE_EN
      win_idx_q     <= 3'd0;
      win_line_q    <= 3'd0;
      win_hit_q     <= 1'b0;
`endif
    end else begin
      cursor_q      <= cursor_d;
      left_q        <= left_btn;
      right_q       <= right_btn;
      cursor_prev_q <= cursor_q;
      move_prev_q   <= curr_move;
      turn_prev_q   <= curr_turn;
      pending_q     <= pending_d;
      line_q        <= line_d;
      cand_q        <= cand_d;
      legal_q       <= legal_d;
      winner_q      <= winner_d;
      busy_q        <= busy_d;
      next_move_q   <= next_move_d;
      next_state_q  <= next_state_d;
      valid_q       <= valid_d;
`ifdef WIN_LINE_EN
      win_idx_q     <= win_idx_d;
      win_line_q    <= win_line_d;
      win_hit_q     <= win_hit_d;
`endif
    end
  end

  assign cursor     = cursor_q;
  assign next_move  = next_move_q;
  assign next_state = next_state_q;
  assign valid_move = valid_q;
  assign busy       = busy_q;
`ifdef WIN_LINE_EN
  assign win_line   = win_line_q;
  assign win_hit    = win_hit_q;
`endif

endmodule

// File: tb/tb_move_judge.sv
module tb_move_judge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        left_btn = 1'b0;
  logic        right_btn = 1'b0;
  logic [17:0] curr_move = '0;
  logic [1:0]  curr_turn = 2'b01;
  logic [1:0]  curr_state = 2'b00;
  logic [3:0]  cursor;
  logic [17:0] next_move;
  logic [1:0]  next_state;
  logic        valid_move;
  logic        busy;
`ifdef WIN_LINE_EN
  logic [2:0]  win_line;
  logic        win_hit;
`endif

  int checks = 0;
  int failures = 0;

  move_judge dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .left_btn   (left_btn),
    .right_btn  (right_btn),
    .curr_move  (curr_move),
    .curr_turn  (curr_turn),
    .curr_state (curr_state),
    .cursor     (cursor),
    .next_move  (next_move),
    .next_state (next_state),
    .valid_move (valid_move),
    .busy       (busy)
`ifdef WIN_LINE_EN
    ,
    .win_line   (win_line),
    .win_hit    (win_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One button pulse; returns two falling edges later with buttons low.
  task automatic press(input logic l, input logic r);
    @(negedge clk);
    left_btn  = l;
    right_btn = r;
    @(negedge clk);
    left_btn  = 1'b0;
    right_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    repeat (4) @(negedge clk);
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;

    // Reset values.
    @(negedge clk);
    chk("rst_cursor", 32'(cursor), 32'd4);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid_move), 32'd0);
    chk("rst_next_move", 32'(next_move), 32'h0);
    chk("rst_next_state", 32'(next_state), 32'd0);
    reset_n = 1'b1;

    // First scan: busy for exactly 9 clocks.
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
    end
    chk("first_busy_len", 32'(n), 32'd9);
    chk("first_next_move", 32'(next_move), 32'h00100);
    chk("first_next_state", 32'(next_state), 32'd0);
    chk("first_valid", 32'(valid_move), 32'd1);

    // Cursor wrap.
    press(1'b0, 1'b1); chk("right_5", 32'(cursor), 32'd5);
    press(1'b0, 1'b1); chk("right_6", 32'(cursor), 32'd6);
    press(1'b0, 1'b1); chk("right_7", 32'(cursor), 32'd7);
    press(1'b0, 1'b1); chk("right_8", 32'(cursor), 32'd8);
    press(1'b0, 1'b1); chk("right_wrap_0", 32'(cursor), 32'd0);
    press(1'b1, 1'b0); chk("left_wrap_8", 32'(cursor), 32'd8);
    press(1'b1, 1'b1); chk("both_edges", 32'(cursor), 32'd8);

    // A completes the top row.
    curr_move = 18'h00005;
    curr_turn = 2'b01;
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1); chk("cursor_2", 32'(cursor), 32'd2);
    wait_idle("awin");
    chk("awin_next_move", 32'(next_move), 32'h00015);
    chk("awin_next_state", 32'(next_state), 32'd1);
    chk("awin_valid", 32'(valid_move), 32'd1);
`ifdef WIN_LINE_EN
    chk("awin_win_line", 32'(win_line), 32'd0);
    chk("awin_win_hit", 32'(win_hit), 32'd1);
`endif

    // Occupied cell.
    curr_move = 18'h00001;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0); chk("cursor_0", 32'(cursor), 32'd0);
    wait_idle("occ");
    chk("occ_next_move", 32'(next_move), 32'h00001);
    chk("occ_valid", 32'(valid_move), 32'd0);
    chk("occ_next_state", 32'(next_state), 32'd0);

    // B fills the last cell with no line: draw.
    curr_move = 18'h06A59;
    curr_turn = 2'b10;
    press(1'b1, 1'b0); chk("cursor_8", 32'(cursor), 32'd8);
    wait_idle("draw");
    chk("draw_next_move", 32'(next_move), 32'h26A59);
    chk("draw_next_state", 32'(next_state), 32'd3);
    chk("draw_valid", 32'(valid_move), 32'd1);
`ifdef WIN_LINE_EN
    chk("draw_win_hit", 32'(win_hit), 32'd0);
    chk("draw_win_line", 32'(win_line), 32'd0);
`endif

    // Abort: cursor moves mid-scan, scan restarts.
    @(negedge clk);
    curr_move = 18'h0;
    wait_idle("pre_abort");
    chk("pre_abort_next_move", 32'(next_move), 32'h20000);
    @(negedge clk);
    curr_turn = 2'b01;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) begin
        n = 1;
        break;
      end
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (busy) n++;
    end
    right_btn = 1'b1;
    @(negedge clk);
    if (busy) n++;
    right_btn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk("abort_busy_len", 32'(n), 32'd15);
    chk("abort_cursor", 32'(cursor), 32'd0);
    chk("abort_next_move", 32'(next_move), 32'h00001);
    chk("abort_next_state", 32'(next_state), 32'd0);
    chk("abort_valid", 32'(valid_move), 32'd1);

    // Reset mid-scan.
    @(negedge clk);
    curr_turn = 2'b10;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_scan_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(valid_move), 32'd0);
    chk("mid_rst_cursor", 32'(cursor), 32'd4);
    chk("mid_rst_next_move", 32'(next_move), 32'h0);
    chk("mid_rst_next_state", 32'(next_state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
